math_addsub_pipe: RTL and testbench
===================================

# math_addsub_pipe

Parametrised, fully pipelined wide adder/subtractor built from cascaded SEG-bit carry segments, one segment per pipeline stage. It generalises the fixed 96-bit adder to any width, adds a per-sample add/subtract select, an optional signed mode and a valid strobe that travels with the data. It sits in the wide-accumulator and correlation-sum datapaths of the math library, where 64–128-bit sums must close timing at full fabric clock.

## Interface

Parameters:
- WIDTH, 96: operand width in bits (≥ 2).
- SEG, 48: carry-segment width in bits (1..48, one DSP ALU or fabric carry chain).
- SIGNED, 0: 0 = operands unsigned; 1 = operands two's-complement.
- NSEG, derived = ceil(WIDTH/SEG): number of segments. Not user-settable.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- ena  in  1  global clock enable; low stalls every pipeline register.
- in_valid  in  1  dina/dinb/sub qualify a sample this cycle.
- sub  in  1  0 = dina + dinb; 1 = dina − dinb.
- dina  in  WIDTH  operand A.
- dinb  in  WIDTH  operand B.
- out_valid  out  1  dout holds a result.
- dout  out  WIDTH+1  exact result, registered.

## Operation

- Exact result. Unsigned: dout = dina ± dinb in WIDTH+1 bits.
  - Add: dout[WIDTH] = carry out.
  - Sub: dout[WIDTH-1:0] = (dina − dinb) mod 2^WIDTH; dout[WIDTH] = borrow (1 iff dina < dinb).
- Signed: both operands are sign-extended to WIDTH+1 bits first. dout is the exact two's-complement sum or difference and never overflows.
- Subtraction: dina + ~dinb with carry-in 1 to segment 0. Operand inversion and sign extension are applied at the input register.
- Segments: segment k covers bits [k·SEG +: SEG]. The top segment is WIDTH − (NSEG−1)·SEG bits plus the extension bit. Its carry/extension output forms dout[WIDTH].
- Pipeline layout:
  - Stage 0: input register.
  - Stages 1..NSEG: segment k−1 computes in stage k, using the carry registered from segment k−2 in the previous stage.
  - Operand slices for higher segments pass through skew registers. Completed low-segment sums pass through deskew registers so that all slices of one sample align.
  - Final output register drives dout.
- Sample fields: sub and in_valid travel with each sample. Samples with different sub values may be issued back-to-back with no bubbles.
- Invalid cycles: when in_valid = 0, the data registers may update, but out_valid for that slot is 0. dout is don't-care while out_valid = 0.
- Stall: ena = 0 freezes all registers, including out_valid and dout. No sample is lost or duplicated across a stall.
- Priority: rst beats ena. With rst = 1, every register is cleared on that edge regardless of ena.

## Timing

- Latency: NSEG + 2 enabled cycles from an in_valid edge to the out_valid edge.
  - WIDTH = 96, SEG = 48: 4 cycles.
  - WIDTH = 100, SEG = 48: 5 cycles.
- Throughput: one sample per enabled cycle, no bubbles between samples.
- Reset values: out_valid = 0, dout = 0, all internal skew, carry and valid registers = 0.
- First valid output: the earliest one is NSEG + 2 enabled cycles after rst deasserts.
- Reset mid-stream: every in-flight sample is discarded. No out_valid pulse for them appears after reset.
- Critical path: one SEG-bit carry chain plus register. No combinational path from any input to any output.

## Test plan

- WIDTH=96, SEG=48, SIGNED=0: add dina = 2^96−1, dinb = 1, sub = 0.
  -> out_valid 4 cycles later; dout = 2^96 (bit 96 = 1, bits 95:0 = 0).
- WIDTH=96, unsigned subtract, issued back-to-back: (0 − 1), then (5 − 3), then (2^48−1 + 1).
  -> on three consecutive cycles: dout = {1, 96'hFFFF…F}, then 2, then 2^48. The third checks carry across the segment boundary.
- WIDTH=96, SIGNED=1: add −2^95 + −1.
  -> dout = 97-bit pattern: bit 96 = 1, bit 95 = 0, bits 94:0 all 1.
- WIDTH=96, SIGNED=1: subtract 2^95−1 − (−2^95).
  -> dout = 2^96−1 (bit 96 = 0).
- Stall and reset: stream 8 random samples, hold ena = 0 for 3 cycles mid-stream; then repeat, asserting rst for 1 cycle with 3 samples in flight.
  -> Stall: all 8 results appear in order, exact, delayed by 3 cycles.
  -> Reset: out_valid = 0 and dout = 0 the cycle after rst; no stale results emerge.
- WIDTH=100, SEG=48 (NSEG=3): random add/sub stream of 1000 samples compared against a reference model.
  -> latency 5, all results exact.

Source files
------------

// File: rtl/math_addsub_pipe.sv
// Pipelined wide adder/subtractor: one SEG-bit carry segment per stage, operands
// skewed in, partial sums deskewed out, valid strobe travelling with each sample.
module math_addsub_pipe #(
    parameter int WIDTH  = 96,
    parameter int SEG    = 48,
    parameter int SIGNED = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ena,
    input  logic             in_valid,
    input  logic             sub,
    input  logic [WIDTH-1:0] dina,
    input  logic [WIDTH-1:0] dinb,
    output logic             out_valid,
    output logic [WIDTH:0]   dout
);

    localparam int NSEG = (WIDTH + SEG - 1) / SEG;
    localparam int EW   = WIDTH + 1;

    logic [EW-1:0] a_ext_s;
    logic [EW-1:0] b_raw_s;
    logic [EW-1:0] b_ext_s;

    // Skew registers: stage k holds the operands for segment k.
    logic [NSEG-1:0][EW-1:0] a_r;
    logic [NSEG-1:0][EW-1:0] b_r;
    logic [NSEG-1:0]         c_r;
    logic [NSEG:0]           v_r;
    // Deskew registers: s_r[k] holds segments 0..k-1 of one sample.
    logic [NSEG:1][EW-1:0]   s_r;
    logic [NSEG:1][EW-1:0]   s_nxt_s;
    logic [NSEG:1]           c_nxt_s;

    // Extend operands to WIDTH+1 bits; subtract is A + ~B + 1.
    always_comb begin
        if (SIGNED != 0) begin
            a_ext_s = {dina[WIDTH-1], dina};
            b_raw_s = {dinb[WIDTH-1], dinb};
        end else begin
            a_ext_s = {1'b0, dina};
            b_raw_s = {1'b0, dinb};
        end
        b_ext_s = b_raw_s ^ {EW{sub}};
    end

    for (genvar k = 1; k <= NSEG; k++) begin : g_seg
        localparam int LO = (k - 1) * SEG;
        localparam int W  = (k == NSEG) ? (EW - LO) : SEG;

        logic [W:0]    t_s;
        logic [EW-1:0] base_s;
        logic [EW-1:0] seg_s;

        if (k == 1) begin : g_first
            assign base_s = {EW{1'b0}};
        end else begin : g_rest
            assign base_s = s_r[k-1];
        end

        assign t_s = {1'b0, a_r[k-1][LO +: W]} + {1'b0, b_r[k-1][LO +: W]}
                   + {{W{1'b0}}, c_r[k-1]};

        // Splice this segment's sum into the sample's deskewed partial result.
        always_comb begin
            seg_s           = base_s;
            seg_s[LO +: W]  = t_s[W-1:0];
        end

        assign s_nxt_s[k] = seg_s;
        assign c_nxt_s[k] = t_s[W];
    end

    // Pipeline registers; rst wins over ena, ena low freezes everything.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_r       <= '0;
            b_r       <= '0;
            c_r       <= '0;
            v_r       <= '0;
            s_r       <= '0;
            dout      <= '0;
            out_valid <= 1'b0;
        end else if (ena) begin
            a_r[0] <= a_ext_s;
            b_r[0] <= b_ext_s;
            c_r[0] <= sub;
            v_r[0] <= in_valid;
            for (int k = 1; k < NSEG; k++) begin
                a_r[k] <= a_r[k-1];
                b_r[k] <= b_r[k-1];
                c_r[k] <= c_nxt_s[k];
            end
            for (int k = 1; k <= NSEG; k++) begin
                s_r[k] <= s_nxt_s[k];
                v_r[k] <= v_r[k-1];
            end
            dout      <= s_r[NSEG];
            out_valid <= v_r[NSEG];
        end
    end

endmodule

// File: tb/tb_math_addsub_pipe.sv
// Scoreboard bench: three instances (96 unsigned, 96 signed, 100 unsigned) driven
// with directed and random samples, checked against a plain-arithmetic model.
module tb_math_addsub_pipe;

    localparam int LAT0 = 4;
    localparam int LAT2 = 5;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, ena;
    logic v0, s0, v1, s1, v2, s2;
    logic [95:0] a0, b0, a1, b1;
    logic [99:0] a2, b2;
    logic ov0, ov1, ov2;
    logic [96:0] d0, d1;
    logic [100:0] d2;

    math_addsub_pipe #(.WIDTH(96), .SEG(48), .SIGNED(0)) u0 (
        .clk(clk), .rst(rst), .ena(ena), .in_valid(v0), .sub(s0),
        .dina(a0), .dinb(b0), .out_valid(ov0), .dout(d0));
    math_addsub_pipe #(.WIDTH(96), .SEG(48), .SIGNED(1)) u1 (
        .clk(clk), .rst(rst), .ena(ena), .in_valid(v1), .sub(s1),
        .dina(a1), .dinb(b1), .out_valid(ov1), .dout(d1));
    math_addsub_pipe #(.WIDTH(100), .SEG(48), .SIGNED(0)) u2 (
        .clk(clk), .rst(rst), .ena(ena), .in_valid(v2), .sub(s2),
        .dina(a2), .dinb(b2), .out_valid(ov2), .dout(d2));

    typedef struct {
        logic [100:0] exp;
        int           t;
    } item_t;

    item_t q0[$], q1[$], q2[$];
    int n_tests = 0;
    int n_fail  = 0;
    int ecnt    = 0;

    always @(posedge clk) if (ena && !rst) ecnt++;

    task automatic check(input string name, input logic [100:0] act, input logic [100:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic mon(input int id, input logic ov, input logic [100:0] d);
        item_t it;
        bit    got;
        int    lat;
        if (!ov) return;
        got = 1'b0;
        lat = (id == 2) ? LAT2 : LAT0;
        case (id)
            0: if (q0.size() > 0) begin it = q0.pop_front(); got = 1'b1; end
            1: if (q1.size() > 0) begin it = q1.pop_front(); got = 1'b1; end
            default: if (q2.size() > 0) begin it = q2.pop_front(); got = 1'b1; end
        endcase
        if (!got) begin
            n_tests++;
            n_fail++;
            $display("FAIL unexpected_out dut%0d: got out_valid=1 expected no result", id);
            return;
        end
        check($sformatf("dout dut%0d", id), d, it.exp);
        check($sformatf("latency dut%0d", id), 101'(ecnt - it.t), 101'(lat));
    endtask

    // Monitor: one look per enabled edge, after the outputs settle.
    always @(posedge clk) begin
        if (ena && !rst) begin
            #1;
            mon(0, ov0, {4'b0, d0});
            mon(1, ov1, {4'b0, d1});
            mon(2, ov2, d2);
        end
    end

    function automatic logic [100:0] ref_model(input int w, input bit sgn, input logic sb,
                                               input logic [99:0] a, input logic [99:0] b);
        logic [100:0] lo_mask, ea, eb, r;
        lo_mask = (101'd1 << w) - 101'd1;
        ea = {1'b0, a} & lo_mask;
        eb = {1'b0, b} & lo_mask;
        if (sgn && a[w-1]) ea = ea | ~lo_mask;
        if (sgn && b[w-1]) eb = eb | ~lo_mask;
        r = sb ? (ea - eb) : (ea + eb);
        return r & ((101'd1 << (w + 1)) - 101'd1);
    endfunction

    function automatic logic [99:0] rand_op();
        case ($urandom_range(0, 3))
            0:       return {100{1'b1}};
            1:       return 100'd0;
            default: return 100'({$urandom, $urandom, $urandom, $urandom});
        endcase
    endfunction

    task automatic issue(input int id, input logic sb, input logic [99:0] a,
                         input logic [99:0] b, input logic [100:0] exp);
        item_t it;
        it.exp = exp;
        it.t   = ecnt;
        case (id)
            0: begin v0 = 1'b1; s0 = sb; a0 = a[95:0]; b0 = b[95:0]; q0.push_back(it); end
            1: begin v1 = 1'b1; s1 = sb; a1 = a[95:0]; b1 = b[95:0]; q1.push_back(it); end
            default: begin v2 = 1'b1; s2 = sb; a2 = a; b2 = b; q2.push_back(it); end
        endcase
    endtask

    task automatic issue_rand(input int id);
        logic        sb;
        logic [99:0] a, b;
        int          w;
        sb = 1'($urandom);
        a  = rand_op();
        b  = rand_op();
        w  = (id == 2) ? 100 : 96;
        if (id != 2) begin
            a[99:96] = 4'b0;
            b[99:96] = 4'b0;
        end
        issue(id, sb, a, b, ref_model(w, id == 1, sb, a, b));
    endtask

    task automatic next_cycle();
        @(negedge clk);
        v0 = 1'b0; v1 = 1'b0; v2 = 1'b0;
    endtask

    task automatic drain(input int n);
        ena = 1'b1;
        repeat (n) next_cycle();
    endtask

    task automatic check_cleared(input string tag);
        check({tag, " ov0"}, {100'd0, ov0}, 101'd0);
        check({tag, " d0"},  {4'b0, d0},    101'd0);
        check({tag, " ov1"}, {100'd0, ov1}, 101'd0);
        check({tag, " d1"},  {4'b0, d1},    101'd0);
        check({tag, " ov2"}, {100'd0, ov2}, 101'd0);
        check({tag, " d2"},  d2,            101'd0);
    endtask

    initial begin
        rst = 1'b1; ena = 1'b1;
        v0 = 1'b0; s0 = 1'b0; a0 = '0; b0 = '0;
        v1 = 1'b0; s1 = 1'b0; a1 = '0; b1 = '0;
        v2 = 1'b0; s2 = 1'b0; a2 = '0; b2 = '0;
        repeat (3) @(negedge clk);
        @(posedge clk);
        #1 check_cleared("reset");
        @(negedge clk);
        rst = 1'b0;

        // Directed corner cases on the 96-bit instances, issued back-to-back.
        next_cycle();
        issue(0, 1'b0, {4'b0, {96{1'b1}}}, 100'd1, {4'b0, 1'b1, 96'h0});
        issue(1, 1'b0, {4'b0, 1'b1, 95'h0}, {4'b0, {96{1'b1}}}, {4'b0, 2'b10, {95{1'b1}}});
        next_cycle();
        issue(0, 1'b1, 100'd0, 100'd1, {4'b0, 1'b1, {96{1'b1}}});
        issue(1, 1'b1, {4'b0, 1'b0, {95{1'b1}}}, {4'b0, 1'b1, 95'h0}, {4'b0, 1'b0, {96{1'b1}}});
        next_cycle();
        issue(0, 1'b1, 100'd5, 100'd3, 101'd2);
        next_cycle();
        issue(0, 1'b0, 100'hFFFF_FFFF_FFFF, 100'd1, 101'h1_0000_0000_0000);
        drain(10);

        // Eight random samples with a three-cycle stall in the middle.
        for (int i = 0; i < 8; i++) begin
            if (i == 4) begin
                repeat (3) begin
                    next_cycle();
                    ena = 1'b0;
                end
            end
            next_cycle();
            ena = 1'b1;
            for (int id = 0; id < 3; id++) issue_rand(id);
        end
        drain(10);

        // Reset with three samples in flight: none of them may emerge.
        for (int i = 0; i < 3; i++) begin
            next_cycle();
            for (int id = 0; id < 3; id++) issue_rand(id);
        end
        next_cycle();
        rst = 1'b1;
        q0.delete(); q1.delete(); q2.delete();
        @(posedge clk);
        #1 check_cleared("midreset");
        @(negedge clk);
        rst = 1'b0;
        drain(10);

        // Long random stream with random gaps and random stalls.
        for (int i = 0; i < 1000; i++) begin
            next_cycle();
            ena = ($urandom_range(0, 9) != 0);
            if (ena) begin
                for (int id = 0; id < 3; id++)
                    if ($urandom_range(0, 4) != 0) issue_rand(id);
            end
        end
        drain(12);

        check("leftover q0", 101'(q0.size()), 101'd0);
        check("leftover q1", 101'(q1.size()), 101'd0);
        check("leftover q2", 101'(q2.size()), 101'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
